// File: rtl/nand_unit_arbiter.sv
// Round-robin scheduler sharing one registered NAND/INVERT unit between NREQ requesters.
// Latency: request handshake in cycle T, tagged result valid in cycle T+2; one op per 3 cycles at best.
// Backpressure: requesters hold until req_ready; the result is held stable until rsp_ready.
module nand_unit_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ-1:0]         req_op,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_q
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_live;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_gnt;
  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_rsp_q;
  logic [IDW-1:0]   r_rsp_id;

  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [NREQ-1:0]  w_req_ready;
  logic             w_take;
  logic [WIDTH-1:0] w_result;

  // Marks the first edge after reset release; no grant is offered before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_live <= 1'b0;
    else        r_live <= 1'b1;
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_rr_ptr) + k) % NREQ]) begin
        w_found = 1'b1;
        w_gnt   = IDW'((int'(r_rr_ptr) + k) % NREQ);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state and the one-hot accept strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_take      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (r_live && w_found) begin
          w_req_ready[w_gnt] = 1'b1;
          w_take             = 1'b1;
          w_state_nxt        = EXEC;
        end
      end
      EXEC:    w_state_nxt = RESP;
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The shared evaluation unit: b is ignored for INVERT.
  assign w_result = r_op ? ~r_a : ~(r_a & r_b);

  // Operand capture on accept, result registration in EXEC, pointer advance on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rsp_q  <= '0;
      r_rsp_id <= '0;
    end else begin
      if (w_take) begin
        r_gnt <= w_gnt;
        r_op  <= req_op[w_gnt];
        r_a   <= req_a[int'(w_gnt)*WIDTH +: WIDTH];
        r_b   <= req_b[int'(w_gnt)*WIDTH +: WIDTH];
      end
      if (r_state == EXEC) begin
        r_rsp_q  <= w_result;
        r_rsp_id <= r_gnt;
      end
      if (r_state == RESP && rsp_ready) begin
        r_rr_ptr <= (r_gnt == IDW'(NREQ-1)) ? '0 : r_gnt + IDW'(1);
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = (r_state == RESP);
  assign rsp_q     = r_rsp_q;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_nand_unit_arbiter.sv
// Directed bench for nand_unit_arbiter with a queue-based response scoreboard.
// Stimulus pushes the hand-computed tagged result at each grant; a monitor pops on completion.
// Grant order, latency, hold under backpressure and mid-operation reset are checked inline.
module tb_nand_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_op;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_q;

  typedef struct {
    logic [1:0] id;
    logic [7:0] q;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] exp_tab [NREQ];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  int         last_cyc = 0;

  nand_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: a result is consumed on the cycle rsp_valid and rsp_ready are both high.
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got id=%0d q=%h, expected no response", rsp_id, rsp_q);
      end else begin
        mon_e = sb_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_q",  32'(rsp_q),  32'(mon_e.q));
      end
    end
  end

  // Waits for the next grant, checks it is exp_g, queues the expected result.
  // chk_gap: grant must be 3 cycles after the previous one. chk_lat: rsp_valid rises at T+2.
  task automatic wait_grant(input int exp_g, input bit chk_gap, input bit chk_lat);
    bit         got;
    logic [3:0] e_rdy;
    got   = 1'b0;
    e_rdy = 4'b0001 << exp_g;
    for (int c = 0; c < 30 && !got; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        got = 1'b1;
        check("req_ready", 32'(req_ready), 32'(e_rdy));
        sb_q.push_back('{id: 2'(exp_g), q: exp_tab[exp_g]});
        if (chk_gap) check("grant_gap", 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL grant_timeout: got no grant, expected requester %0d", exp_g);
    end else if (chk_lat) begin
      @(negedge clk);
      check("rsp_valid_T+1", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("rsp_valid_T+2", 32'(rsp_valid), 32'd1);
    end
  endtask

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 40 && sb_q.size() != 0; c++) @(negedge clk);
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    drive_edge();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Operands are constant; expected results are hand-computed per requester.
    //   r0 NAND FF,0F -> F0 ; r1 INV A5 -> 5A ; r2 NAND F0,3C -> CF ; r3 INV 00 -> FF
    exp_tab   = '{8'hF0, 8'h5A, 8'hCF, 8'hFF};
    req_op    = 4'b1010;
    req_a     = {8'h00, 8'hF0, 8'hA5, 8'hFF};
    req_b     = {8'h00, 8'h3C, 8'h00, 8'h0F};
    rst_n     = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;

    // Reset held with every requester valid.
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_q",     32'(rsp_q),     32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    drive_edge();
    rst_n = 1'b1;
    @(negedge clk);
    check("release_req_ready", 32'(req_ready), 32'd0);

    // Round robin from requester 0 with all valid: 0,1,2,3,0.
    wait_grant(0, 1'b0, 1'b1);
    wait_grant(1, 1'b1, 1'b1);
    wait_grant(2, 1'b1, 1'b1);
    wait_grant(3, 1'b1, 1'b1);
    wait_grant(0, 1'b1, 1'b1);
    drive_edge();
    req_valid = 4'b0000;
    drain();

    // Single NAND from requester 2 (pointer now at 1).
    req_valid = 4'b0100;
    wait_grant(2, 1'b0, 1'b1);
    drive_edge();
    req_valid = 4'b0000;
    @(negedge clk);
    check("post_done_valid", 32'(rsp_valid), 32'd0);
    check("post_done_q_held", 32'(rsp_q), 32'hCF);
    drain();

    // Invert from requester 1 with 5 cycles of backpressure (pointer at 3, search 3,0,1).
    rsp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(1, 1'b0, 1'b1);
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_q",     32'(rsp_q),     32'h5A);
      check("bp_id",    32'(rsp_id),    32'd1);
    end
    drive_edge();
    rsp_ready = 1'b1;
    drive_edge();
    @(negedge clk);
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    drain();

    // Wrap/skip: grant 2 moves pointer to 3, then only 0 and 3 valid -> 3 then 0.
    req_valid = 4'b0100;
    wait_grant(2, 1'b0, 1'b1);
    drive_edge();
    req_valid = 4'b1001;
    wait_grant(3, 1'b0, 1'b1);
    wait_grant(0, 1'b1, 1'b1);
    drive_edge();
    // Eight operations with everyone valid: nobody starved.
    req_valid = 4'b1111;
    wait_grant(1, 1'b0, 1'b1);
    wait_grant(2, 1'b1, 1'b1);
    wait_grant(3, 1'b1, 1'b1);
    wait_grant(0, 1'b1, 1'b1);
    wait_grant(1, 1'b1, 1'b1);
    wait_grant(2, 1'b1, 1'b1);
    wait_grant(3, 1'b1, 1'b1);
    wait_grant(0, 1'b1, 1'b1);
    drive_edge();
    req_valid = 4'b0000;
    drain();

    // Mid-operation reset during EXEC of a requester 1 operation (pointer at 1).
    req_valid = 4'b0010;
    wait_grant(1, 1'b0, 1'b0);
    drive_edge();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rsp_valid), 32'd0);
    check("midrst_q",     32'(rsp_q),     32'd0);
    check("midrst_id",    32'(rsp_id),    32'd0);
    sb_q.delete();
    repeat (2) drive_edge();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    // Pointer restored to 0: with 0 and 1 valid, 0 wins.
    drive_edge();
    req_valid = 4'b0011;
    wait_grant(0, 1'b0, 1'b1);
    drive_edge();
    req_valid = 4'b0000;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nand_unit_arbiter.md
Name: nand_unit_arbiter

Overview:
- Shares one registered WIDTH-bit NAND/invert evaluation unit between NREQ requesters.
- Fair round-robin grant, valid/ready handshake on both the request and response sides.
- Each response is tagged with the index of the requester it belongs to.
- Sits above the gate-level invert/NAND primitives: it is the scheduler that lets several bit-vector clients time-multiplex a single datapath instance.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand/result bit width (>=1).
- IDW, $clog2(NREQ), width of the requester index; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept strobe; one-hot or zero.
- req_op  in  NREQ  per-requester op: 0 = NAND(a,b), 1 = INVERT(a); b is ignored when op=1.
- req_a  in  NREQ*WIDTH  packed operand A; requester i owns bits [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  packed operand B, same packing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_q  out  WIDTH  result.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, rr_ptr=0, grant register=0, operand registers=0.
- Reset outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0.
- Reset release takes effect at the next rising edge.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[g]=1 combinationally in the same cycle; that cycle is the request handshake.
  - On the edge: capture req_op[g], req_a slice g, req_b slice g and g; go to EXEC.
  - No valid requests: req_ready=0, stay in IDLE.
- EXEC:
  - req_ready=0.
  - Result = ~(a & b) when op=0, ~a when op=1, bitwise over WIDTH bits.
  - Result is registered into rsp_q and g into rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_q and rsp_id are held stable until rsp_ready=1.
  - On the edge with rsp_ready=1: rsp_valid drops to 0, rr_ptr = (g+1) mod NREQ, go to IDLE.
  - Request acceptance and response completion never overlap.
- req_ready is 0 in EXEC and RESP. Requesters must hold req_valid and their operands until they see req_ready.
- Latency and throughput:
  - Handshake in cycle T gives rsp_valid=1 in cycle T+2.
  - Best-case throughput is one operation per 3 cycles.
- Fairness:
  - A requester that keeps req_valid asserted is granted within NREQ grants.
  - rr_ptr only advances on response completion.
- rsp_ready high outside RESP is ignored.
- rsp_q and rsp_id keep their last values after completion and until the next EXEC; rsp_valid qualifies them.
- rr_ptr wraps from NREQ-1 to 0.
- A requester dropping req_valid before being granted is legal; it is simply not granted.
- req_valid changing while the FSM is in EXEC or RESP has no effect until IDLE.
- Reset mid-operation (EXEC or RESP): the in-flight transaction is discarded with no response, and every reset value above is restored.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1, then release → req_ready=0, rsp_valid=0, rsp_q=0, rsp_id=0. First grant goes to requester 0.
- Single NAND: req 2 valid, op=0, a=8'hF0, b=8'h3C, rsp_ready=1 → req_ready=4'b0100 at T. rsp_valid=1 at T+2 with rsp_q=8'hCF, rsp_id=2.
- Invert with backpressure: req 1, op=1, a=8'hA5, rsp_ready=0 for 5 cycles → rsp_valid stays 1 with rsp_q=8'h5A, rsp_id=1 stable. Completion happens on the edge with rsp_ready=1.
- Round-robin: all 4 requesters held valid, rsp_ready=1 → grant order 0,1,2,3,0, one grant per 3 cycles, each rsp_id matching its grant.
- Wrap/skip: rr_ptr=3 after granting req 2, only req 0 and req 3 valid → req 3 granted first, then req 0. No requester is starved over 8 operations.
- Mid-operation reset: assert rst_n=0 asynchronously during EXEC of a req-1 operation → rsp_valid=0 immediately, no response ever appears. The next grant after release follows rr_ptr=0.
